// File: rtl/depacketizer_1.sv
// NoC endpoint depacketizer: checks flit framing/VC, drops malformed flits, delivers data through a 2-entry skid FIFO.
// Optional dropped-flit counter enabled by defining DEPACKETIZER_1_ERR_COUNT_EN.
module depacketizer_1 #(
   parameter int                          ADDRESS_WIDTH    = 4,
   parameter int                          VC_ADDRESS_WIDTH = 1,
   parameter int                          WIDTH_IN         = 36,
   parameter int                          WIDTH_OUT        = 10,
   parameter logic [VC_ADDRESS_WIDTH-1:0] ASSIGNED_VC      = '0
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [WIDTH_IN-1:0]      i_data_in,
   input  logic                     i_valid_in,
   output logic                     i_ready_out,
   output logic [WIDTH_OUT-1:0]     o_data_out,
   output logic [ADDRESS_WIDTH-1:0] o_dest_out,
   output logic                     o_valid_out,
   input  logic                     o_ready_in,
   output logic [7:0]               o_err_count
);

   localparam int HALF    = WIDTH_IN / 2;
   localparam int AVAIL   = HALF - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
   localparam int DATA_W  = (WIDTH_OUT < AVAIL) ? WIDTH_OUT : AVAIL;
   localparam int VC_HI   = HALF - 4;
   localparam int DEST_HI = VC_HI - VC_ADDRESS_WIDTH;
   localparam int DATA_HI = DEST_HI - ADDRESS_WIDTH;
   localparam int ENTRY_W = ADDRESS_WIDTH + WIDTH_OUT;

   logic                        flit_valid;
   logic                        flit_head;
   logic                        flit_tail;
   logic [VC_ADDRESS_WIDTH-1:0] flit_vc;
   logic [ADDRESS_WIDTH-1:0]    flit_dest;
   logic [WIDTH_OUT-1:0]        flit_word;
   logic                        well_formed;
   logic                        accept;
   logic                        push;
   logic                        pop;
   logic                        unused_bits;

   logic [ENTRY_W-1:0] mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic [1:0]         count_next;
   logic               ready_q;

   assign flit_valid = i_data_in[HALF-1];
   assign flit_head  = i_data_in[HALF-2];
   assign flit_tail  = i_data_in[HALF-3];
   assign flit_vc    = i_data_in[VC_HI -: VC_ADDRESS_WIDTH];
   assign flit_dest  = i_data_in[DEST_HI -: ADDRESS_WIDTH];
   // Upper half and padding are deliberately ignored.
   assign unused_bits = ^i_data_in;

   always_comb begin
      flit_word = '0;
      flit_word[WIDTH_OUT-1 -: DATA_W] = i_data_in[DATA_HI -: DATA_W];
   end

   assign well_formed = flit_valid & flit_head & flit_tail & (flit_vc == ASSIGNED_VC);
   assign accept      = i_valid_in & i_ready_out;
   assign push        = accept & well_formed;
   assign pop         = o_valid_out & o_ready_in;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count   <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count   <= count_next;
         ready_q <= (count_next != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {flit_dest, flit_word};
   end

   assign i_ready_out              = ready_q;
   assign o_valid_out              = (count != 2'd0);
   assign {o_dest_out, o_data_out} = mem[rd_ptr];

`ifdef DEPACKETIZER_1_ERR_COUNT_EN
   logic       drop;
   logic [7:0] err_cnt;

   assign drop = accept & ~well_formed;

   always_ff @(posedge clk) begin
      if (!rstn)                         err_cnt <= '0;
      else if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end

   assign o_err_count = err_cnt;
`else
   assign o_err_count = '0;
`endif

endmodule
